regfile_sb: RTL

Parametrised multi-port integer register file with a per-register pending-write scoreboard. Issue logic uses it to read operands and reserve destinations. Writeback ports update data and retire reservations. Optional same-cycle write-to-read bypass is supported, and a flush clears all reservations. It replaces the single-write, two-read register file in the core and sits between decode/issue and the writeback stage.

---
 rtl/regfile_sb.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Multi-port integer register file with a per-register
//               pending-write scoreboard. Issue reads operands and reserves
//               destinations; writeback ports update data and retire
//               reservations. Optional same-cycle write-to-read bypass,
//               plus a flush that clears every reservation.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int PEND_W   = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [RD_PORTS-1:0][AW-1:0]        rd_addr,
  output logic [RD_PORTS-1:0][DATA_W-1:0]    rd_data,
  output logic [RD_PORTS-1:0]                rd_busy,
  input  logic [WR_PORTS-1:0]                wr_en,
  input  logic [WR_PORTS-1:0][AW-1:0]        wr_addr,
  input  logic [WR_PORTS-1:0][DATA_W-1:0]    wr_data,
  input  logic                               alloc_en,
  input  logic [AW-1:0]                      alloc_addr,
  output logic                               alloc_stall,
  input  logic                               flush
);

  // Width able to count every write port hitting one register.
  localparam int CW = $clog2(WR_PORTS + 1);
  // Common width for comparing a hit count against a pending counter.
  localparam int SW = (PEND_W > CW) ? PEND_W : CW;
  localparam logic [PEND_W-1:0] c_pend_max = '1;

  // Architectural state: x0 is never written, so it stays at reset value.
  logic [DATA_W-1:0] r_data [REG_NUM];
  logic [PEND_W-1:0] r_pend [REG_NUM];

  // Per-register write decode (x0 excluded).
  logic [REG_NUM-1:0] w_we;
  logic [DATA_W-1:0]  w_wd   [REG_NUM];
  logic [CW-1:0]      w_cnt  [REG_NUM];
  logic [PEND_W-1:0]  w_dec  [REG_NUM];
  logic [REG_NUM-1:0] w_inc;
  logic [PEND_W-1:0]  w_pend_nxt [REG_NUM];

  logic w_stall;
  logic w_alloc_ok;

  // Decode write ports per register; ascending scan so the highest port wins.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      w_we[r]  = 1'b0;
      w_wd[r]  = '0;
      w_cnt[r] = '0;
      for (int p = 0; p < WR_PORTS; p++) begin
        if ((r != 0) && wr_en[p] && (wr_addr[p] == AW'(r))) begin
          w_we[r]  = 1'b1;
          w_wd[r]  = wr_data[p];
          w_cnt[r] = w_cnt[r] + CW'(1);
        end
      end
    end
  end

  // A saturated destination can only take a new reservation if a write
  // retires one in the same cycle.
  assign w_stall     = (alloc_addr != '0) && (r_pend[alloc_addr] == c_pend_max)
                       && !w_we[alloc_addr];
  assign w_alloc_ok  = alloc_en && (alloc_addr != '0) && !w_stall;
  assign alloc_stall = w_stall;

  // Retire count is capped at the outstanding count (untracked writes retire nothing).
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      w_dec[r] = (SW'(w_cnt[r]) > SW'(r_pend[r])) ? r_pend[r] : PEND_W'(w_cnt[r]);
      w_inc[r] = w_alloc_ok && (alloc_addr == AW'(r));
      w_pend_nxt[r] = flush ? '0 : (r_pend[r] + PEND_W'(w_inc[r]) - w_dec[r]);
    end
  end

  // State update: data writes always land, counters follow alloc/retire/flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < REG_NUM; r++) begin
        r_data[r] <= '0;
        r_pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (w_we[r]) begin
          r_data[r] <= w_wd[r];
        end
        r_pend[r] <= w_pend_nxt[r];
      end
    end
  end

  // Read ports: combinational, optionally forwarding same-cycle writes.
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [AW-1:0] w_a;
    assign w_a = rd_addr[i];
    if (BYPASS != 0) begin : g_byp
      assign rd_data[i] = (w_a == '0) ? '0 : (w_we[w_a] ? w_wd[w_a] : r_data[w_a]);
      assign rd_busy[i] = (r_pend[w_a] - w_dec[w_a]) != '0;
    end else begin : g_nobyp
      assign rd_data[i] = (w_a == '0) ? '0 : r_data[w_a];
      assign rd_busy[i] = r_pend[w_a] != '0;
    end
  end

endmodule
`default_nettype wire
